mux_share_arbiter: RTL and testbench
====================================

// Module: mux_share_arbiter
// PURPOSE
// Round-robin arbiter that shares one 2:1 mux datapath (z = sel ? b : a) between
// two requesters, A and B. It drives the mux select, runs a valid/ready handshake
// on the shared output and acks each requester per accepted beat. A burst cap
// stops either side from starving the other. Sits between two producer ports and
// the single downstream consumer.
// PARAMETERS
// W          8   data width of a_data, b_data, z_data
// MAX_BURST  4   max consecutive beats per grant while the other side requests (>=1)
// PORTS
// clk       in   1          rising-edge clock
// rst_n     in   1          async active-low reset
// a_req     in   1          A has a beat; held with a_data stable until a_ack
// a_data    in   W          A payload
// a_ack     out  1          A beat accepted this cycle (comb)
// b_req     in   1          B has a beat; held with b_data stable until b_ack
// b_data    in   W          B payload
// b_ack     out  1          B beat accepted this cycle (comb)
// z_valid   out  1          shared output valid (comb)
// z_data    out  W          sel ? b_data : a_data (comb)
// z_ready   in   1          downstream accepts when z_valid & z_ready
// sel       out  1          registered mux select: 0 = A, 1 = B
// busy      out  1          registered; 1 in any GRANT state
// BEHAVIOUR
// - Reset (async, immediate): state=IDLE, sel=0, last=1 (B), cnt=0, busy=0;
//   z_valid=a_ack=b_ack=0. An in-flight beat is dropped and never acked.
// - States: IDLE, GRANT_A (sel=0), GRANT_B (sel=1). sel and busy are registered.
// - xfer = z_valid & z_ready. a_ack = xfer & ~sel; b_ack = xfer & sel.
// - IDLE: z_valid=0. If only a_req -> GRANT_A. If only b_req -> GRANT_B. If
//   both -> grant the side != last. If neither, stay. cnt=0. sel holds its value.
// - GRANT_A: z_valid=a_req. Symmetric rules apply in GRANT_B.
//   * a_req=0 (A done): last=A, cnt=0. Next state is GRANT_B if b_req, else IDLE.
//     This costs one bubble cycle.
//   * xfer and b_req and cnt==MAX_BURST-1: -> GRANT_B, last=A, cnt=0. There is
//     no bubble; B's first beat is offered the next cycle.
//   * xfer otherwise: stay. cnt=min(cnt+1, MAX_BURST-1).
//   * no xfer (z_ready=0): hold state, sel and cnt. Never switch mid-beat.
// - Grant changes only at beat boundaries. z_data follows sel, so it is stable
//   while stalled as long as requesters obey the hold rule.
// - With one requester active alone, it streams one beat per cycle. The cap only
//   applies while the other side requests.
// - Latency: req in IDLE -> z_valid on the next cycle. A back-to-back switch on
//   the cap adds 0 cycles. A switch on req drop adds 1 idle cycle.
// - cnt width = clog2(MAX_BURST)+1 bits. With MAX_BURST=1 the grant alternates
//   every beat while both sides request.
// - a_req falling without an ack is a protocol violation. The block treats it as
//   "A done" and returns to arbitration.
// TESTING
// 1. rst_n=0 with a_req=b_req=1 -> z_valid=0, a_ack=b_ack=0, sel=0, busy=0.
// 2. Only a_req=1, a_data=8'h5A, z_ready=1 -> cycle 1 IDLE->GRANT_A. Cycle 2:
//    z_valid=1, z_data=8'h5A, a_ack=1, sel=0, busy=1.
// 3. a_req=b_req=1 held, z_ready=1, MAX_BURST=4 -> ack pattern AAAABBBBAAAA with
//    no z_valid gaps after the first grant. With MAX_BURST=1 -> ABABAB.
// 4. GRANT_A with cnt=3 and b_req=1, z_ready=0 for 3 cycles -> sel=0, z_data and
//    cnt stable, no acks. On z_ready=1: a_ack pulses, then the next cycle sel=1.
// 5. A takes 2 beats, then drops a_req while b_req=1 -> one cycle of z_valid=0,
//    then GRANT_B with b_ack on the following beat, and last=A.
// 6. rst_n pulsed low mid-burst in GRANT_B -> outputs reset within the same
//    cycle. After release with both req high, A is granted first (last=B).

Source files
------------

// File: rtl/mux_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux_share_arbiter
// Description : Round-robin arbiter sharing one 2:1 mux datapath between two
//               valid/ready requesters, with a burst cap against starvation.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_share_arbiter #(
    parameter int W         = 8,
    parameter int MAX_BURST = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         a_req,
    input  logic [W-1:0] a_data,
    output logic         a_ack,
    input  logic         b_req,
    input  logic [W-1:0] b_data,
    output logic         b_ack,
    output logic         z_valid,
    output logic [W-1:0] z_data,
    input  logic         z_ready,
    output logic         sel,
    output logic         busy
);

    localparam int            c_CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [c_CNT_W-1:0] c_CAP = c_CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT_A = 2'd1,
        S_GRANT_B = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_stateNext;
    state_t               w_otherState;
    logic                 r_last;
    logic                 w_lastNext;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cntNext;
    logic                 r_sel;
    logic                 r_busy;
    logic                 w_grant;
    logic                 w_isB;
    logic                 w_ownReq;
    logic                 w_otherReq;
    logic                 w_xfer;

    // Owner/other views let both grant states share one set of rules.
    assign w_grant      = (r_state != S_IDLE);
    assign w_isB        = (r_state == S_GRANT_B);
    assign w_ownReq     = w_isB ? b_req : a_req;
    assign w_otherReq   = w_isB ? a_req : b_req;
    assign w_otherState = w_isB ? S_GRANT_A : S_GRANT_B;

    assign z_valid = w_grant & w_ownReq;
    assign w_xfer  = z_valid & z_ready;
    assign a_ack   = w_xfer & ~r_sel;
    assign b_ack   = w_xfer &  r_sel;
    assign z_data  = r_sel ? b_data : a_data;
    assign sel     = r_sel;
    assign busy    = r_busy;

    always_comb begin
        w_stateNext = r_state;
        w_lastNext  = r_last;
        w_cntNext   = r_cnt;
        case (r_state)
            S_IDLE: begin
                w_cntNext = '0;
                // r_last = 1 means B was served last, so A wins a tie.
                if (a_req && (!b_req || r_last)) begin
                    w_stateNext = S_GRANT_A;
                end else if (b_req) begin
                    w_stateNext = S_GRANT_B;
                end
            end
            S_GRANT_A, S_GRANT_B: begin
                if (!w_ownReq) begin
                    w_lastNext  = w_isB;
                    w_cntNext   = '0;
                    w_stateNext = w_otherReq ? w_otherState : S_IDLE;
                end else if (w_xfer) begin
                    if (w_otherReq && (r_cnt == c_CAP)) begin
                        w_lastNext  = w_isB;
                        w_cntNext   = '0;
                        w_stateNext = w_otherState;
                    end else if (r_cnt != c_CAP) begin
                        w_cntNext = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_stateNext = S_IDLE;
                w_cntNext   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
            r_cnt   <= '0;
            r_sel   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_last  <= w_lastNext;
            r_cnt   <= w_cntNext;
            r_busy  <= (w_stateNext != S_IDLE);
            if (w_stateNext != S_IDLE) begin
                r_sel <= (w_stateNext == S_GRANT_B);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mux_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_share_arbiter
// Description : Directed self-checking bench for mux_share_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_share_arbiter;

    logic       clk;
    logic       rst_n;
    logic       a_req;
    logic [7:0] a_data;
    logic       b_req;
    logic [7:0] b_data;
    logic       z_ready;

    logic       a_ack, b_ack, z_valid, sel, busy;
    logic [7:0] z_data;
    logic       a1Ack, b1Ack, z1Valid, sel1, busy1;
    logic [7:0] z1Data;

    int nVec;
    int nErr;

    localparam logic [7:0] c_DA = 8'h5A;
    localparam logic [7:0] c_DB = 8'hC3;

    mux_share_arbiter #(.W(8), .MAX_BURST(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_data(a_data), .a_ack(a_ack),
        .b_req(b_req), .b_data(b_data), .b_ack(b_ack),
        .z_valid(z_valid), .z_data(z_data), .z_ready(z_ready),
        .sel(sel), .busy(busy)
    );

    mux_share_arbiter #(.W(8), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_data(a_data), .a_ack(a1Ack),
        .b_req(b_req), .b_data(b_data), .b_ack(b1Ack),
        .z_valid(z1Valid), .z_data(z1Data), .z_ready(z_ready),
        .sel(sel1), .busy(busy1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic doReset(input logic aR, input logic bR, input logic zR);
        @(negedge clk);
        rst_n   = 1'b0;
        a_req   = aR;
        b_req   = bR;
        z_ready = zR;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0;
        a_req = 1'b1; b_req = 1'b1; z_ready = 1'b1;
        a_data = c_DA; b_data = c_DB;
        nVec = 0; nErr = 0;

        // Reset held with both requesting
        #12;
        check("rst z_valid", z_valid, 0);
        check("rst a_ack", a_ack, 0);
        check("rst b_ack", b_ack, 0);
        check("rst sel", sel, 0);
        check("rst busy", busy, 0);

        // Single requester A
        a_req = 1'b1; b_req = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("onlyA z_valid", z_valid, 1);
        check("onlyA z_data", z_data, c_DA);
        check("onlyA a_ack", a_ack, 1);
        check("onlyA sel", sel, 0);
        check("onlyA busy", busy, 1);
        @(posedge clk); #1;
        a_req = 1'b0; #1;
        check("dropA z_valid", z_valid, 0);
        check("dropA a_ack", a_ack, 0);
        @(posedge clk); #1;
        check("idle busy", busy, 0);
        check("idle sel hold", sel, 0);
        @(posedge clk); #1;
        check("idle stay busy", busy, 0);

        // Single requester B
        b_req = 1'b1;
        @(posedge clk); #1;
        check("onlyB sel", sel, 1);
        check("onlyB busy", busy, 1);
        check("onlyB z_data", z_data, c_DB);
        check("onlyB b_ack", b_ack, 1);
        check("onlyB a_ack", a_ack, 0);

        // Both requesting continuously: AAAABBBBAAAA (cap 4), ABAB... (cap 1)
        doReset(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 12; k++) begin
            logic expB4;
            logic expB1;
            @(posedge clk); #1;
            expB4 = ((k / 4) % 2) == 1;
            expB1 = (k % 2) == 1;
            check("burst4 z_valid", z_valid, 1);
            check("burst4 a_ack", a_ack, !expB4);
            check("burst4 b_ack", b_ack, expB4);
            check("burst4 z_data", z_data, expB4 ? c_DB : c_DA);
            check("burst1 z_valid", z1Valid, 1);
            check("burst1 a_ack", a1Ack, !expB1);
            check("burst1 b_ack", b1Ack, expB1);
            check("burst1 sel", sel1, expB1);
            check("burst1 busy", busy1, 1);
            check("burst1 z_data", z1Data, expB1 ? c_DB : c_DA);
        end

        // Stall at the cap: no switch mid-beat
        doReset(1'b1, 1'b1, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        z_ready = 1'b0; #1;
        check("stall z_valid", z_valid, 1);
        check("stall a_ack", a_ack, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("stall sel", sel, 0);
            check("stall z_data", z_data, c_DA);
            check("stall a_ack", a_ack, 0);
            check("stall b_ack", b_ack, 0);
        end
        check("stall cnt", dut4.r_cnt, 3);
        z_ready = 1'b1; #1;
        check("unstall a_ack", a_ack, 1);
        @(posedge clk); #1;
        check("capswitch sel", sel, 1);
        check("capswitch b_ack", b_ack, 1);
        check("capswitch z_data", z_data, c_DB);

        // A drops after 2 beats with B waiting: one bubble, then B
        doReset(1'b1, 1'b1, 1'b1);
        @(posedge clk); #1;
        check("drop beat1 a_ack", a_ack, 1);
        @(posedge clk); #1;
        check("drop beat2 a_ack", a_ack, 1);
        @(posedge clk); #1;
        a_req = 1'b0; #1;
        check("bubble z_valid", z_valid, 0);
        check("bubble b_ack", b_ack, 0);
        check("bubble busy", busy, 1);
        @(posedge clk); #1;
        check("afterdrop sel", sel, 1);
        check("afterdrop z_valid", z_valid, 1);
        check("afterdrop b_ack", b_ack, 1);
        check("afterdrop z_data", z_data, c_DB);
        check("afterdrop last", dut4.r_last, 0);

        // Async reset mid-burst in GRANT_B
        @(posedge clk); #1;
        check("midB b_ack", b_ack, 1);
        #2;
        rst_n = 1'b0;
        a_req = 1'b1;
        #1;
        check("async z_valid", z_valid, 0);
        check("async b_ack", b_ack, 0);
        check("async sel", sel, 0);
        check("async busy", busy, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("postrst sel", sel, 0);
        check("postrst a_ack", a_ack, 1);
        check("postrst b_ack", b_ack, 0);
        check("postrst z_data", z_data, c_DA);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
`default_nettype wire
